// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode receiver: frame states, prefix
// codes, silently dropped controller replies and ps2_key field positions.
package ps2_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned KEY_W      = 11;
    localparam int unsigned SKIP_W     = 3;

    localparam int unsigned KEY_TOGGLE = 10;
    localparam int unsigned KEY_PRESS  = 9;
    localparam int unsigned KEY_EXT    = 8;

    typedef logic [1:0] ps2_state_t;
    localparam ps2_state_t ST_IDLE   = 2'd0;
    localparam ps2_state_t ST_DATA   = 2'd1;
    localparam ps2_state_t ST_PARITY = 2'd2;
    localparam ps2_state_t ST_STOP   = 2'd3;

    localparam logic [BYTE_W-1:0] PS2_EXT   = 8'hE0;
    localparam logic [BYTE_W-1:0] PS2_REL   = 8'hF0;
    localparam logic [BYTE_W-1:0] PS2_PAUSE = 8'hE1;

    // Fake shift codes injected by PrintScreen / Ins under an E0 prefix
    localparam logic [BYTE_W-1:0] PS2_FAKE_LSHIFT = 8'h12;
    localparam logic [BYTE_W-1:0] PS2_FAKE_RSHIFT = 8'h59;

    // Bytes of the Pause sequence still to swallow after its leading E1
    localparam int unsigned PAUSE_SKIP = 7;

    // Keyboard replies/status bytes that never map to a key
    function automatic logic is_discard(input logic [BYTE_W-1:0] b);
        case (b)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line receiver: synchronises and filters the raw pins, deserialises
// 11-bit frames and reports each good byte or a frame error as a 1-cycle pulse.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 56000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ps2_clk_i,
    input  logic              ps2_data_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    output logic              frame_err_o
);

    localparam int unsigned FLT_W = 8;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BIT_W = 3;

    logic [1:0]        clk_sync_q, data_sync_q;
    logic              filt_q, filt_d;
    logic [FLT_W-1:0]  flt_cnt_q, flt_cnt_d;
    logic              fall_q, fall_d;
    ps2_state_t        state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              par_ok_q, par_ok_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              data_s;

    assign data_s       = data_sync_q[1];
    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = err_q;

    // Lines idle high, so the synchronisers and filter reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            flt_cnt_q   <= '0;
            fall_q      <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_ok_q    <= 1'b0;
            to_cnt_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            filt_q      <= filt_d;
            flt_cnt_q   <= flt_cnt_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            to_cnt_q    <= to_cnt_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // Level filter: flip only after FILTER_LEN consecutive opposite samples
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '0;
        fall_d    = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
                fall_d = ~clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        to_cnt_d  = '0;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        if (state_q != ST_IDLE && !fall_q) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        if (fall_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d = {data_s, shift_q[BYTE_W-1:1]};
                    if (bit_cnt_q == BIT_W'(BYTE_W - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                ST_PARITY: begin
                    par_ok_d = ^{shift_q, data_s};
                    state_d  = ST_STOP;
                end
                default: begin
                    if (data_s && par_ok_q) begin
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard front end: folds E0/F0/E1 prefix sequences into one
// {toggle, press, extended, code} event word for the ZX matrix block.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 56000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [KEY_W-1:0] ps2_key,
    output logic             frame_err
);

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_valid;
    logic              rx_err;

    logic [KEY_W-1:0]  key_q, key_d;
    logic              ext_q, ext_d;
    logic              rel_q, rel_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              fake_shift;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame (
        .clk          (clk),
        .rst_n        (reset_n),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_err)
    );

    assign ps2_key    = key_q;
    assign frame_err  = rx_err;
    assign fake_shift = (rx_byte == PS2_FAKE_LSHIFT) || (rx_byte == PS2_FAKE_RSHIFT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q  <= '0;
            ext_q  <= 1'b0;
            rel_q  <= 1'b0;
            skip_q <= '0;
        end else begin
            key_q  <= key_d;
            ext_q  <= ext_d;
            rel_q  <= rel_d;
            skip_q <= skip_d;
        end
    end

    // Prefix decoder; first matching rule wins
    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        if (rx_err) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = '0;
        end else if (rx_valid) begin
            if (skip_q != '0) begin
                skip_d = skip_q - SKIP_W'(1);
            end else if (rx_byte == PS2_PAUSE) begin
                skip_d = SKIP_W'(PAUSE_SKIP);
            end else if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_REL) begin
                rel_d = 1'b1;
            end else if (ext_q && fake_shift) begin
                ext_d = 1'b0;
                rel_d = 1'b0;
            end else if (ext_q || rel_q || !is_discard(rx_byte)) begin
                key_d[KEY_TOGGLE]   = ~key_q[KEY_TOGGLE];
                key_d[KEY_PRESS]    = ~rel_q;
                key_d[KEY_EXT]      = ext_q;
                key_d[BYTE_W-1:0]   = rx_byte;
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: drives PS/2 frames and checks ps2_key and
// frame_err every cycle against a scancode-level model of the event word.
module tb_ps2_scancode_rx;

    localparam int unsigned FILTER_LEN     = 8;
    localparam int unsigned TIMEOUT_CYCLES = 1000;
    localparam int          HALF           = 20;
    // 2 synchroniser stages, FILTER_LEN filter samples, then strobe -> byte_valid -> ps2_key
    localparam int          KEY_LAT        = 2 + FILTER_LEN + 2;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    ps2_scancode_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [10:0] exp_key = '0;
    bit          m_ext, m_rel, m_tog;
    int          m_skip;
    bit          pend_key_v, pend_err_v;
    logic [10:0] pend_key;
    int          pend_key_cyc, pend_err_cyc;
    bit          chk_en  = 1'b0;
    bit          err_chk = 1'b1;
    int          err_pulses = 0;
    int          e0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        logic exp_err;
        if (pend_key_v && cyc == pend_key_cyc) begin
            exp_key    = pend_key;
            pend_key_v = 1'b0;
        end
        exp_err = pend_err_v && (cyc == pend_err_cyc);
        if (exp_err) pend_err_v = 1'b0;
        if (chk_en) begin
            check("ps2_key", 32'(ps2_key), 32'(exp_key));
            if (err_chk) check("frame_err", 32'(frame_err), 32'(exp_err));
        end
        if (frame_err) err_pulses++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            compare();
        end
    endtask

    task automatic model_clear();
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
    endtask

    // Scancode-level rules for one received byte whose stop bit fell at cycle n
    task automatic model_byte(input logic [7:0] b, input int n);
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (!m_ext && !m_rel && b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF}) begin
            // controller reply, no event
        end else if (m_ext && (b == 8'h12 || b == 8'h59)) begin
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else begin
            m_tog        = ~m_tog;
            pend_key     = {m_tog, ~m_rel, m_ext, b};
            pend_key_v   = 1'b1;
            pend_key_cyc = n + KEY_LAT;
            m_ext        = 1'b0;
            m_rel        = 1'b0;
        end
    endtask

    task automatic model_err(input int n);
        pend_err_v   = 1'b1;
        pend_err_cyc = n + KEY_LAT - 1;
        model_clear();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        logic [10:0] bits;
        int          n;
        bits = {1'b1, bad_par ? ^b : ~^b, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            tick(HALF / 2);
            if (glitch) begin
                ps2_clk = 1'b0;
                tick(1);
                ps2_clk = 1'b1;
                tick(HALF / 2 - 1);
            end else begin
                tick(HALF / 2);
            end
            ps2_clk = 1'b0;
            n = cyc;
            if (i == 10) begin
                if (bad_par) model_err(n);
                else         model_byte(b, n);
            end
            if (glitch) begin
                tick(HALF / 2);
                ps2_clk = 1'b1;
                tick(1);
                ps2_clk = 1'b0;
                tick(HALF / 2 - 1);
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b1;
        end
        tick(HALF);
    endtask

    // Start bit plus nbits data bits, then the clock is left high
    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i <= nbits; i++) begin
            ps2_data = bits[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_frame(s[i], 1'b0, 1'b0);
    endtask

    task automatic pin(input string name, input logic [10:0] lit);
        check({name, "_dut"}, 32'(ps2_key), 32'(lit));
        check({name, "_model"}, 32'(exp_key), 32'(lit));
    endtask

    initial begin
        model_clear();
        m_tog      = 1'b0;
        pend_key_v = 1'b0;
        pend_err_v = 1'b0;
        tick(3);
        check("rst_key", 32'(ps2_key), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick(5);

        send_seq('{8'h1C});              pin("a_press", 11'h61C);
        send_seq('{8'hF0, 8'h1C});       pin("a_release", 11'h01C);
        send_seq('{8'hE0, 8'h75});       pin("ext_press", 11'h775);
        send_seq('{8'hE0, 8'hF0, 8'h75}); pin("ext_release", 11'h175);

        e0 = err_pulses;
        send_frame(8'h1C, 1'b1, 1'b0);
        check("parity_err_pulses", 32'(err_pulses - e0), 32'd1);
        pin("parity_err_key", 11'h175);
        send_seq('{8'h1C});              pin("after_parity", 11'h61C);
        send_seq('{8'hFA});              pin("discard_fa", 11'h61C);
        send_seq('{8'h1C});              pin("typematic", 11'h21C);

        err_chk = 1'b0;
        e0 = err_pulses;
        send_partial(8'h29, 4);
        tick(TIMEOUT_CYCLES - 50);
        check("timeout_early", 32'(err_pulses - e0), 32'd0);
        tick(150);
        check("timeout_pulses", 32'(err_pulses - e0), 32'd1);
        err_chk = 1'b1;
        send_seq('{8'h29});              pin("after_timeout", 11'h629);

        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
        pin("pause", 11'h629);
        send_seq('{8'hE0, 8'h12, 8'hE0, 8'h7C}); pin("prtscr", 11'h37C);

        send_frame(8'h1C, 1'b0, 1'b1);   pin("glitch", 11'h61C);

        send_partial(8'h55, 3);
        reset_n = 1'b0;
        exp_key = '0;
        m_tog   = 1'b0;
        model_clear();
        pend_key_v = 1'b0;
        pend_err_v = 1'b0;
        tick(3);
        check("midreset_key", 32'(ps2_key), 32'h0);
        check("midreset_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        tick(HALF);
        send_seq('{8'h1C});              pin("after_reset", 11'h61C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
